// File: rtl/decrypt_scan_pkg.sv
// Shared constants for the keystream-protected scan segment.
// Default sizes, LFSR feedback taps and filter taps for the 128-bit keystream generator.
package decrypt_scan_pkg;

  localparam int DSC_CHAIN_LEN     = 128;
  localparam int DSC_KEY_W         = 128;
  localparam int DSC_WARMUP_CYCLES = 128;

  // Feedback taps: fb = lfsr[127] ^ lfsr[6] ^ lfsr[1] ^ lfsr[0]
  localparam int FB_TAP0 = 127;
  localparam int FB_TAP1 = 6;
  localparam int FB_TAP2 = 1;
  localparam int FB_TAP3 = 0;

  // Filter taps: ks = lfsr[127] ^ lfsr[95] ^ (lfsr[63] & lfsr[31])
  localparam int KS_LIN_TAP0 = 127;
  localparam int KS_LIN_TAP1 = 95;
  localparam int KS_AND_TAP0 = 63;
  localparam int KS_AND_TAP1 = 31;

  // An all-zero LFSR would lock up, so a zero key is replaced by this seed
  localparam logic [DSC_KEY_W-1:0] ZERO_KEY_SEED = 128'h1;

endpackage

// File: rtl/dsc_keystream_gen.sv
// Keystream generator: 128-bit Fibonacci LFSR with nonlinear filter, warm-up counter and ready flag.
// The LFSR is seeded asynchronously from initial_key while reset_n_ka is low.
module dsc_keystream_gen
  import decrypt_scan_pkg::*;
#(
  parameter int KEY_W         = DSC_KEY_W,
  parameter int WARMUP_CYCLES = DSC_WARMUP_CYCLES
) (
  input  logic             tck,
  input  logic             reset_n_ka,
  input  logic             en,
  input  logic             start,
  input  logic             step,
  input  logic [KEY_W-1:0] initial_key,
  output logic             ks,
  output logic             ready
);

  localparam int CNT_W = $clog2(WARMUP_CYCLES + 1);
  localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(WARMUP_CYCLES - 1);

  logic [KEY_W-1:0] lfsr;
  logic [KEY_W-1:0] lfsr_next;
  logic [KEY_W-1:0] seed;
  logic [CNT_W-1:0] wcnt;
  logic             fb;

  assign seed      = (initial_key == '0) ? ZERO_KEY_SEED : initial_key;
  assign fb        = lfsr[FB_TAP0] ^ lfsr[FB_TAP1] ^ lfsr[FB_TAP2] ^ lfsr[FB_TAP3];
  assign lfsr_next = {lfsr[KEY_W-2:0], fb};
  assign ks        = lfsr[KS_LIN_TAP0] ^ lfsr[KS_LIN_TAP1] ^ (lfsr[KS_AND_TAP0] & lfsr[KS_AND_TAP1]);

  // Before ready the LFSR free-runs on start; afterwards it advances only per shifted bit.
  always_ff @(posedge tck or negedge reset_n_ka) begin
    if (!reset_n_ka) begin
      lfsr  <= seed;
      wcnt  <= '0;
      ready <= 1'b0;
    end else if (en) begin
      if (!ready) begin
        if (start) begin
          lfsr <= lfsr_next;
          wcnt <= wcnt + 1'b1;
          if (wcnt == WARM_LAST) begin
            ready <= 1'b1;
          end
        end
      end else if (step) begin
        lfsr <= lfsr_next;
      end
    end
  end

endmodule

// File: rtl/decrypt_scan_chain.sv
// Keystream-protected scan segment: decrypts TDI into the scan register, re-encrypts TDO.
// Optional DSC_INTEGRITY_EN adds parity_out, the parity of the shadow captured on each update.
module decrypt_scan_chain
  import decrypt_scan_pkg::*;
#(
  parameter int CHAIN_LEN     = DSC_CHAIN_LEN,
  parameter int KEY_W         = DSC_KEY_W,
  parameter int WARMUP_CYCLES = DSC_WARMUP_CYCLES
) (
  input  logic             tck,
  input  logic             reset_n,
  input  logic             reset_n_ka,
  input  logic             start,
  input  logic             en,
  input  logic             TDI,
  input  logic             shift_en,
  input  logic             update_en,
  input  logic             capture_en,
  input  logic [KEY_W-1:0] initial_key,
  output logic             TDO
`ifdef DSC_INTEGRITY_EN
  ,
  output logic             parity_out
`endif
);

  logic [CHAIN_LEN-1:0] sr;
  logic [CHAIN_LEN-1:0] shadow;
  logic                 ks;
  logic                 ready;
  logic                 shift_eff;

  assign shift_eff = en & ready & shift_en & ~capture_en;

  dsc_keystream_gen #(
    .KEY_W        (KEY_W),
    .WARMUP_CYCLES(WARMUP_CYCLES)
  ) u_ks (
    .tck        (tck),
    .reset_n_ka (reset_n_ka),
    .en         (en),
    .start      (start),
    .step       (shift_eff),
    .initial_key(initial_key),
    .ks         (ks),
    .ready      (ready)
  );

  // Capture wins over shift; update samples the pre-edge scan value.
  always_ff @(posedge tck or negedge reset_n) begin
    if (!reset_n) begin
      sr     <= '0;
      shadow <= '0;
    end else if (en) begin
      if (capture_en) begin
        sr <= shadow;
      end else if (shift_eff) begin
        sr <= {sr[CHAIN_LEN-2:0], TDI ^ ks};
      end
      if (update_en) begin
        shadow <= sr;
      end
    end
  end

`ifdef DSC_INTEGRITY_EN
  always_ff @(posedge tck or negedge reset_n) begin
    if (!reset_n) begin
      parity_out <= 1'b0;
    end else if (en && update_en) begin
      parity_out <= ^sr;
    end
  end
`endif

  // Same ks bit as the concurrent shift, so plaintext never leaves the die.
  assign TDO = ready & (sr[CHAIN_LEN-1] ^ ks);

endmodule

// File: tb/tb_decrypt_scan_chain.sv
// Directed self-checking bench for decrypt_scan_chain with an independent keystream model.
module tb_decrypt_scan_chain;

  logic         tck;
  logic         reset_n;
  logic         reset_n_ka;
  logic         start;
  logic         en;
  logic         TDI;
  logic         shift_en;
  logic         update_en;
  logic         capture_en;
  logic [127:0] initial_key;
  logic         TDO;
`ifdef DSC_INTEGRITY_EN
  logic         parity_out;
`endif

  int total = 0;
  int bad   = 0;
  logic [127:0] m_lfsr;

  localparam logic [127:0] KEY1  = 128'h0123456789abcdef0123456789abcdef;
  localparam logic [127:0] PAT_A = {32{4'hA}};
  localparam logic [127:0] PAT_5 = {32{4'h5}};

  decrypt_scan_chain dut (
    .tck        (tck),
    .reset_n    (reset_n),
    .reset_n_ka (reset_n_ka),
    .start      (start),
    .en         (en),
    .TDI        (TDI),
    .shift_en   (shift_en),
    .update_en  (update_en),
    .capture_en (capture_en),
    .initial_key(initial_key),
    .TDO        (TDO)
`ifdef DSC_INTEGRITY_EN
    ,
    .parity_out (parity_out)
`endif
  );

  initial tck = 1'b0;
  always #5 tck = ~tck;

  function automatic logic [127:0] m_step(input logic [127:0] s);
    return {s[126:0], s[127] ^ s[6] ^ s[1] ^ s[0]};
  endfunction

  function automatic logic m_ks(input logic [127:0] s);
    return s[127] ^ s[95] ^ (s[63] & s[31]);
  endfunction

  task automatic next_cycle();
    @(posedge tck);
    #1;
  endtask

  // Shift 128 plaintext bits MSB first; dout = decrypted TDO, raw = TDO as seen on the pin.
  task automatic shift_vec(input logic [127:0] din, input int pause_at,
                           output logic [127:0] dout, output logic [127:0] raw);
    for (int i = 127; i >= 0; i--) begin
      if (i == pause_at) begin
        en = 1'b0;
        shift_en = 1'b1;
        repeat (10) next_cycle();
        en = 1'b1;
      end
      shift_en = 1'b1;
      TDI = din[i] ^ m_ks(m_lfsr);
      #1;
      raw[i]  = TDO;
      dout[i] = TDO ^ m_ks(m_lfsr);
      @(posedge tck);
      m_lfsr = m_step(m_lfsr);
      #1;
    end
    shift_en = 1'b0;
    TDI = 1'b0;
  endtask

  task automatic do_update();
    update_en = 1'b1;
    next_cycle();
    update_en = 1'b0;
  endtask

  task automatic do_capture();
    capture_en = 1'b1;
    next_cycle();
    capture_en = 1'b0;
  endtask

  task automatic run_warmup(output int n);
    n = 0;
    start = 1'b1;
    for (int c = 0; c < 300; c++) begin
      next_cycle();
      n++;
      if (dut.ready) break;
    end
  endtask

  task automatic test_reset();
    total++;
    if (TDO !== 1'b0 || dut.ready !== 1'b0) begin
      bad++; $display("FAIL reset_outputs: TDO=%b ready=%b, want 0 0", TDO, dut.ready);
    end
    total++;
    if (dut.sr !== '0 || dut.shadow !== '0) begin
      bad++; $display("FAIL reset_regs: sr=%h shadow=%h, want 0", dut.sr, dut.shadow);
    end
    total++;
    if (dut.u_ks.lfsr !== KEY1) begin
      bad++; $display("FAIL reset_seed: lfsr=%h want %h", dut.u_ks.lfsr, KEY1);
    end
  endtask

  task automatic test_gating_not_ready();
    logic tdo_seen;
    tdo_seen = 1'b0;
    reset_n = 1'b1;
    reset_n_ka = 1'b1;
    m_lfsr = KEY1;
    for (int i = 0; i < 8; i++) begin
      shift_en = 1'b1;
      TDI = i[0];
      #1;
      tdo_seen = tdo_seen | TDO;
      next_cycle();
    end
    shift_en = 1'b0;
    total++;
    if (tdo_seen !== 1'b0) begin
      bad++; $display("FAIL notready_tdo: TDO went %b, want 0", tdo_seen);
    end
    total++;
    if (dut.sr !== '0 || dut.ready !== 1'b0) begin
      bad++; $display("FAIL notready_sr: sr=%h ready=%b, want 0 0", dut.sr, dut.ready);
    end
    total++;
    if (dut.u_ks.lfsr !== KEY1) begin
      bad++; $display("FAIL notready_lfsr: lfsr=%h want %h", dut.u_ks.lfsr, KEY1);
    end
  endtask

  task automatic test_warmup();
    int n;
    run_warmup(n);
    for (int i = 0; i < 128; i++) m_lfsr = m_step(m_lfsr);
    total++;
    if (n !== 128) begin
      bad++; $display("FAIL warmup_cycles: ready after %0d cycles, want 128", n);
    end
    total++;
    if (dut.u_ks.lfsr !== m_lfsr) begin
      bad++; $display("FAIL warmup_lfsr: lfsr=%h want %h", dut.u_ks.lfsr, m_lfsr);
    end
  endtask

  task automatic test_round_trip();
    logic [127:0] d, raw;
    shift_vec(PAT_A, -1, d, raw);
    total++;
    if (d !== '0) begin
      bad++; $display("FAIL rt_first_out: got %h want 0", d);
    end
    do_update();
    total++;
    if (dut.shadow !== PAT_A) begin
      bad++; $display("FAIL rt_shadow: shadow=%h want %h", dut.shadow, PAT_A);
    end
`ifdef DSC_INTEGRITY_EN
    total++;
    if (parity_out !== ^PAT_A) begin
      bad++; $display("FAIL rt_parity: got %b want %b", parity_out, ^PAT_A);
    end
`endif
    do_capture();
    shift_vec('0, -1, d, raw);
    total++;
    if (d !== PAT_A) begin
      bad++; $display("FAIL rt_decrypt: got %h want %h", d, PAT_A);
    end
  endtask

  task automatic test_en_gating();
    logic [127:0] d, raw;
    logic [127:0] p;
    p = KEY1;
    shift_vec(p, 60, d, raw);
    total++;
    if (dut.u_ks.lfsr !== m_lfsr || dut.sr !== p) begin
      bad++; $display("FAIL en_hold: sr=%h want %h lfsr=%h want %h", dut.sr, p, dut.u_ks.lfsr, m_lfsr);
    end
    do_update();
    do_capture();
    shift_vec('0, -1, d, raw);
    total++;
    if (d !== p) begin
      bad++; $display("FAIL en_roundtrip: got %h want %h", d, p);
    end
  endtask

  task automatic test_priority();
    logic [127:0] d, raw, x, y, z;
    x = 128'hdeadbeef_0badf00d_cafef00d_12345678;
    y = 128'h0f0f0f0f_f0f0f0f0_33333333_cccccccc;
    z = 128'h80000000_00000001_7fffffff_fffffffe;
    shift_vec(x, -1, d, raw);
    do_update();
    shift_vec(y, -1, d, raw);
    capture_en = 1'b1;
    shift_en = 1'b1;
    TDI = 1'b1;
    next_cycle();
    capture_en = 1'b0;
    shift_en = 1'b0;
    TDI = 1'b0;
    total++;
    if (dut.sr !== x || dut.u_ks.lfsr !== m_lfsr) begin
      bad++; $display("FAIL prio_capture: sr=%h want %h lfsr=%h want %h", dut.sr, x, dut.u_ks.lfsr, m_lfsr);
    end
    shift_vec(z, -1, d, raw);
    update_en = 1'b1;
    capture_en = 1'b1;
    next_cycle();
    update_en = 1'b0;
    capture_en = 1'b0;
    total++;
    if (dut.sr !== x || dut.shadow !== z) begin
      bad++; $display("FAIL prio_swap: sr=%h want %h shadow=%h want %h", dut.sr, x, dut.shadow, z);
    end
    shift_vec('0, -1, d, raw);
    total++;
    if (d !== x) begin
      bad++; $display("FAIL prio_out: got %h want %h", d, x);
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] d, raw, p;
    p = 128'h13579bdf_2468ace0_fedcba98_76543210;
    for (int i = 0; i < 40; i++) begin
      shift_en = 1'b1;
      TDI = 1'b1 ^ m_ks(m_lfsr);
      @(posedge tck);
      m_lfsr = m_step(m_lfsr);
      #1;
    end
    shift_en = 1'b0;
    reset_n = 1'b0;
    #2;
    total++;
    if (dut.sr !== '0 || dut.shadow !== '0 || dut.ready !== 1'b1) begin
      bad++; $display("FAIL rstn_mid: sr=%h shadow=%h ready=%b, want 0 0 1", dut.sr, dut.shadow, dut.ready);
    end
    reset_n = 1'b1;
    next_cycle();
    shift_vec(p, -1, d, raw);
    do_update();
    do_capture();
    shift_vec('0, -1, d, raw);
    total++;
    if (d !== p) begin
      bad++; $display("FAIL rstn_align: got %h want %h", d, p);
    end
  endtask

  task automatic test_reset_ka();
    logic [127:0] d, raw;
    shift_vec('1, -1, d, raw);
    reset_n_ka = 1'b0;
    #1;
    total++;
    if (dut.ready !== 1'b0 || TDO !== 1'b0) begin
      bad++; $display("FAIL rstka_drop: ready=%b TDO=%b, want 0 0", dut.ready, TDO);
    end
  endtask

  task automatic test_zero_key();
    logic [127:0] d, raw;
    int n;
    initial_key = '0;
    next_cycle();
    total++;
    if (dut.u_ks.lfsr !== 128'h1) begin
      bad++; $display("FAIL zkey_seed: lfsr=%h want 1", dut.u_ks.lfsr);
    end
    m_lfsr = 128'h1;
    reset_n_ka = 1'b1;
    run_warmup(n);
    for (int i = 0; i < 128; i++) m_lfsr = m_step(m_lfsr);
    total++;
    if (n !== 128 || dut.u_ks.lfsr !== m_lfsr) begin
      bad++; $display("FAIL zkey_warmup: cycles=%0d lfsr=%h want 128 %h", n, dut.u_ks.lfsr, m_lfsr);
    end
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    next_cycle();
    shift_vec(PAT_5, -1, d, raw);
    total++;
    if (raw === '0 || raw === '1) begin
      bad++; $display("FAIL zkey_ks_const: raw TDO=%h, want non-constant", raw);
    end
    do_update();
    do_capture();
    shift_vec('0, -1, d, raw);
    total++;
    if (d !== PAT_5) begin
      bad++; $display("FAIL zkey_roundtrip: got %h want %h", d, PAT_5);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    reset_n_ka = 1'b0;
    start = 1'b0;
    en = 1'b1;
    TDI = 1'b0;
    shift_en = 1'b0;
    update_en = 1'b0;
    capture_en = 1'b0;
    initial_key = KEY1;
    m_lfsr = KEY1;
    repeat (3) next_cycle();
    test_reset();
    test_gating_not_ready();
    test_warmup();
    test_round_trip();
    test_en_gating();
    test_priority();
    test_reset_mid();
    test_reset_ka();
    test_zero_key();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
